// File: rtl/vram_wr_sync.sv
// Buffers CPU VRAM writes in a FIFO and commits them to the PPU VRAM port only during vblank,
// so PPU memory never changes mid-frame.
module vram_wr_sync #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             h2f_wraddr,
  input  logic                          h2f_wren,
  input  logic [DATA_W-1:0]             h2f_wrdata,
  input  logic [DATA_W/8-1:0]           h2f_byteena,
  input  logic                          h2f_sync_req,
  input  logic                          vblank,
  input  logic                          vblank_start,
  input  logic                          err_clr,
  output logic [ADDR_W-1:0]             vram_wraddr,
  output logic                          vram_wren,
  output logic [DATA_W-1:0]             vram_wrdata,
  output logic [DATA_W/8-1:0]           vram_byteena,
  output logic                          cpu_wr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_overflow,
  output logic                          err_busy_wr
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned IdxW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = IdxW + 1;
  localparam int unsigned EntW  = ADDR_W + DATA_W + BeW;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StWaitVb, StDrain} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic                ovf_q, ovf_d;
  logic                bwr_q, bwr_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BeW-1:0]      be_q, be_d;

  logic [EntW-1:0]     mem_q [FIFO_DEPTH];
  logic [EntW-1:0]     rd_ent;

  logic                push, pop;
  logic                ovf_set, bwr_set;
  logic                fifo_full, fifo_empty;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[IdxW] != rptr_q[IdxW]) &&
                      (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign rd_ent     = mem_q[rptr_q[IdxW-1:0]];

  // FSM next state, FIFO push/pop and error set events.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    bwr_set = h2f_wren & busy_q;
    unique case (state_q)
      StIdle: begin
        if (h2f_wren) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        if (h2f_sync_req) begin
          state_d = StWaitVb;
        end
      end
      StWaitVb: begin
        // Only a fresh vblank_start counts; a vblank already underway is skipped.
        if (vblank_start) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StIdle;
        end else if (vblank) begin
          pop = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d = (state_d != StIdle);
    wptr_d = wptr_q + {{IdxW{1'b0}}, push};
    rptr_d = rptr_q + {{IdxW{1'b0}}, pop};
    // A set event wins over a same-cycle clear.
    ovf_d  = ovf_set | (ovf_q & ~err_clr);
    bwr_d  = bwr_set | (bwr_q & ~err_clr);
  end

  // Registered VRAM outputs hold their last value between writes.
  always_comb begin
    wren_d = pop;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (pop) begin
      {addr_d, data_d, be_d} = rd_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[IdxW-1:0]] <= {h2f_wraddr, h2f_wrdata, h2f_byteena};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      bwr_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      bwr_q   <= bwr_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign vram_wraddr  = addr_q;
  assign vram_wren    = wren_q;
  assign vram_wrdata  = data_q;
  assign vram_byteena = be_q;
  assign cpu_wr_busy  = busy_q;
  assign fifo_count   = wptr_q - rptr_q;
  assign err_overflow = ovf_q;
  assign err_busy_wr  = bwr_q;

endmodule

// File: tb/tb_vram_wr_sync.sv
// Scoreboard bench for vram_wr_sync: accepted CPU writes are queued as expected VRAM writes and
// a negedge monitor checks every vram_wren beat against the queue.
module tb_vram_wr_sync;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = 8;
  localparam int unsigned DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] h2f_wraddr = '0;
  logic              h2f_wren = 1'b0;
  logic [DATA_W-1:0] h2f_wrdata = '0;
  logic [BE_W-1:0]   h2f_byteena = '0;
  logic              h2f_sync_req = 1'b0;
  logic              vblank = 1'b0;
  logic              vblank_start = 1'b0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] vram_wraddr;
  logic              vram_wren;
  logic [DATA_W-1:0] vram_wrdata;
  logic [BE_W-1:0]   vram_byteena;
  logic              cpu_wr_busy;
  logic [6:0]        fifo_count;
  logic              err_overflow;
  logic              err_busy_wr;

  vram_wr_sync #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h2f_wraddr   (h2f_wraddr),
    .h2f_wren     (h2f_wren),
    .h2f_wrdata   (h2f_wrdata),
    .h2f_byteena  (h2f_byteena),
    .h2f_sync_req (h2f_sync_req),
    .vblank       (vblank),
    .vblank_start (vblank_start),
    .err_clr      (err_clr),
    .vram_wraddr  (vram_wraddr),
    .vram_wren    (vram_wren),
    .vram_wrdata  (vram_wrdata),
    .vram_byteena (vram_byteena),
    .cpu_wr_busy  (cpu_wr_busy),
    .fifo_count   (fifo_count),
    .err_overflow (err_overflow),
    .err_busy_wr  (err_busy_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [BE_W-1:0]   b;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_seen = 0;
  int  base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [BE_W-1:0] b, input bit accept);
    h2f_wraddr  = a;
    h2f_wrdata  = d;
    h2f_byteena = b;
    h2f_wren    = 1'b1;
    if (accept) sb.push_back('{a: a, d: d, b: b});
    tick();
    h2f_wren = 1'b0;
  endtask

  task automatic pulse_sync();
    h2f_sync_req = 1'b1;
    tick();
    h2f_sync_req = 1'b0;
  endtask

  task automatic vb_start();
    vblank       = 1'b1;
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (cpu_wr_busy && n < 300) begin
      tick();
      n++;
    end
    chk(name, {63'd0, cpu_wr_busy}, 64'd0);
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int i);
    return {32'hD00D_0000 + i[31:0], 32'hCAFE_0000 ^ (i[31:0] * 32'd7)};
  endfunction

  // Monitor: every VRAM write must match the oldest expected entry.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && vram_wren) begin
        checks++;
        wr_seen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h be=%0h required no write",
                   vram_wraddr, vram_wrdata, vram_byteena);
        end else begin
          e = sb.pop_front();
          if ({vram_wraddr, vram_wrdata, vram_byteena} !== e) begin
            errors++;
            $display("FAIL vram_write: got addr=%0h data=%0h be=%0h required addr=%0h data=%0h be=%0h",
                     vram_wraddr, vram_wrdata, vram_byteena, e.a, e.d, e.b);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset_ctrl", {54'd0, vram_wren, cpu_wr_busy, err_overflow, err_busy_wr, fifo_count[5:0]},
        64'd0);
    chk("reset_fifo_count", {57'd0, fifo_count}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic commit with cycle-exact timing
    cpu_wr(13'h0010, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    cpu_wr(13'h0011, 64'h5555_6666_7777_8888, 8'h0F, 1'b1);
    cpu_wr(13'h1FFF, 64'h9999_AAAA_BBBB_CCCC, 8'h80, 1'b1);
    chk("basic_count", {57'd0, fifo_count}, 64'd3);
    pulse_sync();
    chk("basic_busy_after_sync", {63'd0, cpu_wr_busy}, 64'd1);
    base = wr_seen;
    vb_start();
    chk("basic_wren_c1", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("basic_wren_c2", {63'd0, vram_wren}, 64'd1);
    tick();
    chk("basic_wren_c3", {63'd0, vram_wren}, 64'd1);
    tick();
    chk("basic_wren_c4", {63'd0, vram_wren}, 64'd1);
    chk("basic_busy_c4", {63'd0, cpu_wr_busy}, 64'd1);
    tick();
    chk("basic_wren_c5", {63'd0, vram_wren}, 64'd0);
    chk("basic_busy_c5", {63'd0, cpu_wr_busy}, 64'd0);
    chk("basic_count_end", {57'd0, fifo_count}, 64'd0);
    chk("basic_nwrites", 64'(wr_seen - base), 64'd3);
    vblank = 1'b0;
    tick();

    // Overflow: the 65th write is dropped
    for (int i = 0; i < 65; i++) begin
      cpu_wr(13'h0200 + 13'(i), mk_data(i), 8'(i * 3 + 1), i < 64);
    end
    chk("ovf_count", {57'd0, fifo_count}, 64'd64);
    chk("ovf_flag", {63'd0, err_overflow}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", {63'd0, err_overflow}, 64'd0);
    base = wr_seen;
    pulse_sync();
    vb_start();
    wait_idle("ovf_drain_done");
    chk("ovf_nwrites", 64'(wr_seen - base), 64'd64);
    vblank = 1'b0;
    tick();

    // Busy drop; vblank already in progress is not used; set beats same-cycle clear
    cpu_wr(13'h0300, mk_data(100), 8'h3C, 1'b1);
    cpu_wr(13'h0301, mk_data(101), 8'hC3, 1'b1);
    pulse_sync();
    vblank  = 1'b1;
    err_clr = 1'b1;
    cpu_wr(13'h0100, mk_data(999), 8'hFF, 1'b0);
    err_clr = 1'b0;
    chk("busy_wr_flag", {63'd0, err_busy_wr}, 64'd1);
    chk("busy_wr_count", {57'd0, fifo_count}, 64'd2);
    base = wr_seen;
    repeat (4) tick();
    chk("busy_old_vblank_nowr", 64'(wr_seen - base), 64'd0);
    chk("busy_old_vblank_busy", {63'd0, cpu_wr_busy}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("busy_wr_clr", {63'd0, err_busy_wr}, 64'd0);
    vblank = 1'b0;
    tick();
    vb_start();
    wait_idle("busy_drain_done");
    chk("busy_nwrites", 64'(wr_seen - base), 64'd2);
    vblank = 1'b0;
    tick();

    // vblank ends mid-drain: 10 vblank cycles give 9 writes
    for (int i = 0; i < 64; i++) begin
      cpu_wr(13'h0400 + 13'(i), mk_data(200 + i), 8'(8'hA5 ^ i), 1'b1);
    end
    base = wr_seen;
    pulse_sync();
    vb_start();
    repeat (9) tick();
    vblank = 1'b0;
    repeat (5) tick();
    chk("mid_partial_writes", 64'(wr_seen - base), 64'd9);
    chk("mid_busy_paused", {63'd0, cpu_wr_busy}, 64'd1);
    chk("mid_count_left", {57'd0, fifo_count}, 64'd55);
    vb_start();
    wait_idle("mid_drain_done");
    chk("mid_total_writes", 64'(wr_seen - base), 64'd64);
    vblank = 1'b0;
    tick();

    // Empty sync acts as a frame handshake
    base = wr_seen;
    pulse_sync();
    chk("empty_busy", {63'd0, cpu_wr_busy}, 64'd1);
    vb_start();
    chk("empty_busy_in_drain", {63'd0, cpu_wr_busy}, 64'd1);
    tick();
    chk("empty_busy_drop", {63'd0, cpu_wr_busy}, 64'd0);
    chk("empty_nwrites", 64'(wr_seen - base), 64'd0);
    vblank = 1'b0;
    tick();

    // Write in the same cycle as sync is committed
    h2f_sync_req = 1'b1;
    cpu_wr(13'h0042, 64'h0042_0042_DEAD_BEEF, 8'h5A, 1'b1);
    h2f_sync_req = 1'b0;
    chk("same_cycle_busy", {63'd0, cpu_wr_busy}, 64'd1);
    chk("same_cycle_count", {57'd0, fifo_count}, 64'd1);
    base = wr_seen;
    vb_start();
    wait_idle("same_cycle_done");
    chk("same_cycle_nwrites", 64'(wr_seen - base), 64'd1);
    vblank = 1'b0;
    tick();

    // Reset mid-drain abandons the rest
    for (int i = 0; i < 20; i++) begin
      cpu_wr(13'h0800 + 13'(i), mk_data(500 + i), 8'hFF, 1'b1);
    end
    base = wr_seen;
    pulse_sync();
    vb_start();
    for (int n = 0; n < 100 && (wr_seen - base) < 5; n++) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl_zero", {54'd0, vram_wren, cpu_wr_busy, err_overflow, err_busy_wr,
                          fifo_count[5:0]}, 64'd0);
    chk("rst_fifo_count", {57'd0, fifo_count}, 64'd0);
    chk("rst_data_zero", vram_wrdata, 64'd0);
    chk("rst_addr_be_zero", {43'd0, vram_wraddr, vram_byteena}, 64'd0);
    sb.delete();
    vblank = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_writes_before", 64'(wr_seen - base), 64'd5);
    chk("post_rst_count", {57'd0, fifo_count}, 64'd0);
    base = wr_seen;
    pulse_sync();
    vb_start();
    repeat (4) tick();
    chk("post_rst_nowr", 64'(wr_seen - base), 64'd0);
    wait_idle("post_rst_idle");
    vblank = 1'b0;
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
